hole_hit_scan: RTL and testbench

- Downstream consumer of the randomized hole-position list produced by the hole position generator.
- On request, scans all MAX_NUM hole positions against the current ball position and reports whether the ball has fallen into a hole.
- Reports the lowest-index hole hit and the minimum squared distance.
- Feeds the game-state controller, which decides on loss or restart.

---
 rtl/hole_hit_scan.sv | 105 ++++++++++
 tb/tb_hole_hit_scan.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hole_hit_scan.sv
// hole_hit_scan: pipelined scan of a snapshotted hole list against the ball position,
// reporting the lowest-index hole inside the capture radius and the minimum squared distance.
module hole_hit_scan #(
  parameter int MAX_NUM = 9,
  parameter int RADIUS  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [MAX_NUM*20-1:0] i_hole_list,
  input  logic                  i_list_valid,
  input  logic                  i_start,
  input  logic [9:0]            i_ball_x,
  input  logic [9:0]            i_ball_y,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_hit,
  output logic [3:0]            o_hit_idx,
  output logic [20:0]           o_min_dist2
);
  localparam logic [20:0] R2 = 21'(RADIUS * RADIUS);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [MAX_NUM*20-1:0] list_q;
  logic [9:0] bx_q, by_q;
  logic [3:0] idx;
  logic [9:0] hx [MAX_NUM];
  logic [9:0] hy [MAX_NUM];
  logic [9:0] cur_x, cur_y;
  logic s1_v, s2_v;
  logic [3:0] s1_idx, s2_idx;
  logic [9:0] s1_dx, s1_dy;
  logic [20:0] dx_w, dy_w, s2_d2;
  logic accept, issue;
  for (genvar k = 0; k < MAX_NUM; k++) begin : g_hole
    assign hx[k] = list_q[10*k +: 10];
    assign hy[k] = list_q[10*MAX_NUM + 10*k +: 10];
  end
  assign cur_x  = hx[idx];
  assign cur_y  = hy[idx];
  assign dx_w   = {11'd0, s1_dx};
  assign dy_w   = {11'd0, s1_dy};
  assign accept = state == IDLE && i_start && i_list_valid;
  assign issue  = state == SCAN;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // DRAIN ends only once both pipeline stages are empty, so DONE sees the final accumulation
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LOAD : IDLE;
      LOAD:    state_nx = SCAN;
      SCAN:    state_nx = idx == 4'(MAX_NUM - 1) ? DRAIN : SCAN;
      DRAIN:   state_nx = !s1_v && !s2_v ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != IDLE;
    o_done = state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      list_q      <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      idx         <= '0;
      s1_v        <= 1'b0;
      s1_idx      <= '0;
      s1_dx       <= '0;
      s1_dy       <= '0;
      s2_v        <= 1'b0;
      s2_idx      <= '0;
      s2_d2       <= '0;
      o_hit       <= 1'b0;
      o_hit_idx   <= 4'hF;
      o_min_dist2 <= '1;
    end else begin
      if (accept) begin
        list_q      <= i_hole_list;
        bx_q        <= i_ball_x;
        by_q        <= i_ball_y;
        o_hit       <= 1'b0;
        o_hit_idx   <= 4'hF;
        o_min_dist2 <= '1;
      end
      idx    <= issue ? idx + 4'd1 : '0;
      s1_v   <= issue;
      s1_idx <= idx;
      s1_dx  <= bx_q >= cur_x ? bx_q - cur_x : cur_x - bx_q;
      s1_dy  <= by_q >= cur_y ? by_q - cur_y : cur_y - by_q;
      s2_v   <= s1_v;
      s2_idx <= s1_idx;
      s2_d2  <= dx_w * dx_w + dy_w * dy_w;
      if (s2_v) begin
        if (s2_d2 < R2 && !o_hit) begin
          o_hit     <= 1'b1;
          o_hit_idx <= s2_idx;
        end
        if (s2_d2 < o_min_dist2) o_min_dist2 <= s2_d2;
      end
    end
  end
endmodule

// File: tb/tb_hole_hit_scan.sv
// tb_hole_hit_scan: directed scans checked against a distance-list model and hand-computed results.
module tb_hole_hit_scan;
  localparam int N = 9;
  localparam logic [31:0] RST_RES = {6'd0, 1'b0, 4'hF, 21'h1FFFFF};
  logic i_clk = 0, i_rst_n = 0, i_list_valid = 0, i_start = 0;
  logic [N*20-1:0] i_hole_list;
  logic [9:0] i_ball_x = 0, i_ball_y = 0;
  logic o_busy, o_done, o_hit;
  logic [3:0] o_hit_idx;
  logic [20:0] o_min_dist2;
  int hx [N];
  int hy [N];
  int tests = 0, fails = 0;
  int m_cnt = -1;
  logic [31:0] m_res = RST_RES, f_res = RST_RES;

  hole_hit_scan #(.MAX_NUM(N), .RADIUS(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hole_list(i_hole_list), .i_list_valid(i_list_valid),
    .i_start(i_start), .i_ball_x(i_ball_x), .i_ball_y(i_ball_y), .o_busy(o_busy), .o_done(o_done),
    .o_hit(o_hit), .o_hit_idx(o_hit_idx), .o_min_dist2(o_min_dist2)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_hole_list = '0;
    for (int k = 0; k < N; k++) begin
      i_hole_list[10*k +: 10]       = 10'(hx[k]);
      i_hole_list[10*N + 10*k +: 10] = 10'(hy[k]);
    end
  end

  function automatic logic [31:0] pk(input logic h, input int i, input int m);
    return {6'd0, h, 4'(i), 21'(m)};
  endfunction

  function automatic logic [31:0] model(input int bx, input int by);
    logic h = 0;
    int ix = 15, mn = (1 << 21) - 1, d;
    for (int k = 0; k < N; k++) begin
      d = (bx - hx[k]) * (bx - hx[k]) + (by - hy[k]) * (by - hy[k]);
      if (d < 32 * 32 && !h) begin
        h  = 1;
        ix = k;
      end
      if (d < mn) mn = d;
    end
    return pk(h, ix, mn);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference timeline: accept edge is cycle 0, o_done is cycle 13, idle again after cycle 14
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cnt <= -1;
      m_res <= RST_RES;
    end else if (m_cnt < 0) begin
      if (i_start && i_list_valid) begin
        m_cnt <= 0;
        f_res <= model(int'(i_ball_x), int'(i_ball_y));
      end
    end else begin
      m_cnt <= m_cnt == 13 ? -1 : m_cnt + 1;
      if (m_cnt == 12) m_res <= f_res;
    end
  end

  always @(negedge i_clk) begin
    chk("busy", 32'(o_busy), 32'(m_cnt >= 0));
    chk("done", 32'(o_done), 32'(m_cnt == 13));
    if (m_cnt < 0 || m_cnt == 13) chk("result", {6'd0, o_hit, o_hit_idx, o_min_dist2}, m_res);
  end

  task automatic set_all(input int x, input int y);
    for (int k = 0; k < N; k++) begin
      hx[k] = x;
      hy[k] = y;
    end
  endtask

  task automatic run_scan(input string nm, input int bx, input int by, input logic [31:0] exp, input bit poke);
    int n = 0;
    longint t0;
    @(posedge i_clk); #2;
    i_ball_x = 10'(bx); i_ball_y = 10'(by); i_list_valid = 1; i_start = 1;
    @(posedge i_clk); #2;
    i_start = 0;
    t0 = $time;
    chk({nm, "_model"}, f_res, exp);
    if (poke) begin
      @(posedge i_clk); #2;
      i_start = 1;
      @(posedge i_clk); #2;
      i_start = 0; i_list_valid = 0; i_ball_x = 10'd300; hx[3] = 900;
    end
    while (!o_done && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(($time - t0) / 10), 32'd13);
    chk({nm, "_dut"}, {6'd0, o_hit, o_hit_idx, o_min_dist2}, exp);
    @(negedge i_clk);
    i_list_valid = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_all(1000, 1000);
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1;
    chk("reset_state", 32'({o_busy, o_done, o_hit, o_hit_idx, o_min_dist2}), {7'd0, 4'hF, 21'h1FFFFF});
    set_all(300, 170); hx[3] = 100; hy[3] = 50;
    run_scan("single_hit", 110, 60, pk(1, 3, 200), 0);
    set_all(1000, 1000); hx[0] = 132; hy[0] = 50;
    run_scan("radius_out", 100, 50, pk(0, 15, 1024), 0);
    hx[0] = 131;
    run_scan("radius_in", 100, 50, pk(1, 0, 961), 0);
    set_all(1000, 1000); hx[2] = 50; hy[2] = 50; hx[7] = 51; hy[7] = 50;
    run_scan("multi_hit", 51, 50, pk(1, 2, 0), 0);
    set_all(1000, 1000); hx[4] = 0; hy[4] = 0;
    run_scan("absdiff_pos", 5, 5, pk(1, 4, 50), 0);
    hx[4] = 319; hy[4] = 179;
    run_scan("absdiff_neg", 0, 0, pk(0, 15, 133802), 0);
    @(posedge i_clk); #2;
    i_list_valid = 0; i_start = 1;
    repeat (3) @(negedge i_clk);
    chk("no_valid_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #2;
    i_start = 0;
    set_all(300, 170); hx[3] = 100; hy[3] = 50;
    run_scan("mid_scan_poke", 110, 60, pk(1, 3, 200), 1);
    set_all(1000, 1000); hx[0] = 0; hy[0] = 0;
    @(posedge i_clk); #2;
    i_ball_x = 5; i_ball_y = 5; i_list_valid = 1; i_start = 1;
    @(posedge i_clk); #2;
    i_start = 0;
    repeat (5) @(posedge i_clk);
    #2 chk("pre_reset_hit", 32'({o_busy, o_hit}), 32'b11);
    #1 i_rst_n = 0;
    #1 chk("async_reset", 32'({o_busy, o_done, o_hit, o_hit_idx, o_min_dist2}), {7'd0, 4'hF, 21'h1FFFFF});
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1;
    run_scan("after_reset", 5, 5, pk(1, 0, 50), 0);
    repeat (3) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
